// File: rtl/seq_detector_param.sv
//------------------------------------------------------------------------------
// Module   : seq_detector_param
// Purpose  : Parametrised Moore serial pattern detector. Shifts valid-qualified
//            serial bits into a PAT_W-bit window and compares the window with
//            a run-time loadable pattern register. Supports overlapping and
//            non-overlapping detection, and keeps a saturating match counter.
// Ports    : clk         rising-edge clock
//            rst         synchronous reset, active-low
//            x           serial data bit
//            x_valid     x is sampled only when high
//            overlap     1 = overlapping matches, 0 = window restarts on match
//            pat_load    one-cycle strobe, loads pat_in (and pat_mask_in)
//            pat_in      new pattern
//            pat_mask_in new compare mask (only with SEQ_DET_MASK_EN)
//            cnt_clr     clears match_cnt
//            z           Moore match flag
//            seq         current shift window, newest bit at seq[0]
//            pat         active pattern register
//            match_cnt   saturating match count
// Options  : SEQ_DET_MASK_EN - adds a loadable compare mask (0 = don't-care).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_detector_param #(
  parameter int               PAT_W     = 4,
  parameter int               CNT_W     = 8,
  parameter logic [PAT_W-1:0] PAT_RESET = 4'b1101
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_W-1:0] pat_mask_in,
`endif
  input  logic             cnt_clr,
  output logic             z,
  output logic [PAT_W-1:0] seq,
  output logic [PAT_W-1:0] pat,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int             FW        = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]  FILL_LAST = FW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_HUNT  = 2'd1,
    S_MATCH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] seq_q, seq_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PAT_W-1:0] shift_w;
  logic             hit_w;

  // Window as it would look after shifting in the current bit.
  assign shift_w = {seq_q[PAT_W-2:0], x};

`ifdef SEQ_DET_MASK_EN
  logic [PAT_W-1:0] mask_q, mask_d;
  assign hit_w = (((shift_w ^ pat_q) & mask_q) == '0);
`else
  assign hit_w = (shift_w == pat_q);
`endif

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
`ifdef SEQ_DET_MASK_EN
    mask_d  = mask_q;
`endif
    if (pat_load) begin
      // A load restarts detection; any x on this edge is discarded.
      pat_d   = pat_in;
      seq_d   = '0;
      fill_d  = '0;
      state_d = S_FILL;
`ifdef SEQ_DET_MASK_EN
      mask_d  = pat_mask_in;
`endif
    end else begin
      case (state_q)
        S_FILL: begin
          if (x_valid) begin
            seq_d  = shift_w;
            fill_d = fill_q + FW'(1);
            if (fill_q == FILL_LAST) begin
              state_d = hit_w ? S_MATCH : S_HUNT;
            end
          end
        end
        S_HUNT: begin
          if (x_valid) begin
            seq_d = shift_w;
            if (hit_w) begin
              state_d = S_MATCH;
            end
          end
        end
        S_MATCH: begin
          if (overlap) begin
            state_d = S_HUNT;
            if (x_valid) begin
              seq_d = shift_w;
              if (hit_w) begin
                state_d = S_MATCH;
              end
            end
          end else begin
            // Non-overlap: the bit on this edge starts a fresh window.
            state_d = S_FILL;
            seq_d   = x_valid ? {{(PAT_W-1){1'b0}}, x} : '0;
            fill_d  = x_valid ? FW'(1) : '0;
          end
        end
        default: begin
          state_d = S_FILL;
          seq_d   = '0;
          fill_d  = '0;
        end
      endcase
    end

    // Entering MATCH without a load is always a fresh (re-)match.
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (!pat_load && (state_d == S_MATCH) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FILL;
      seq_q   <= '0;
      fill_q  <= '0;
      pat_q   <= PAT_RESET;
      cnt_q   <= '0;
`ifdef SEQ_DET_MASK_EN
      mask_q  <= '1;
`endif
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
`ifdef SEQ_DET_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign z         = (state_q == S_MATCH);
  assign seq       = seq_q;
  assign pat       = pat_q;
  assign match_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
//------------------------------------------------------------------------------
// Module   : tb_seq_detector_param
// Purpose  : Directed self-checking bench for seq_detector_param. A second
//            instance with CNT_W=2 shares all inputs to exercise saturation.
// Options  : SEQ_DET_MASK_EN - also exercises the compare mask.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       x = 1'b0;
  logic       x_valid = 1'b0;
  logic       overlap = 1'b1;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic [3:0] pat_mask_in = 4'b1111;
  logic       cnt_clr = 1'b0;
  logic       z, z2;
  logic [3:0] seq, seq2, pat, pat2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(4), .CNT_W(8), .PAT_RESET(4'b1101)) u_dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_DET_MASK_EN
    .pat_mask_in(pat_mask_in),
`endif
    .cnt_clr(cnt_clr), .z(z), .seq(seq), .pat(pat), .match_cnt(match_cnt)
  );

  seq_detector_param #(.PAT_W(4), .CNT_W(2), .PAT_RESET(4'b1101)) u_dut2 (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_DET_MASK_EN
    .pat_mask_in(pat_mask_in),
`endif
    .cnt_clr(cnt_clr), .z(z2), .seq(seq2), .pat(pat2), .match_cnt(match_cnt2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and settle, so outputs reflect that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; x_valid = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic send(input logic b);
    x = b; x_valid = 1'b1;
    step();
    x_valid = 1'b0;
  endtask

  // Sends the 7-bit vector MSB first and checks z after every bit.
  task automatic send7(input string tag, input logic [6:0] bits, input logic [6:0] zexp);
    logic [6:0] b, e;
    b = bits; e = zexp;
    for (int i = 6; i >= 0; i--) begin
      send(b[i]);
      check_eq(tag, {31'd0, z}, {31'd0, e[i]});
    end
  endtask

  initial begin
    // ---- Test 1: reset, then basic match ----
    rst = 1'b0;
    step(); step();
    check_eq("rst_z", {31'd0, z}, 32'd0);
    check_eq("rst_seq", {28'd0, seq}, 32'h0);
    check_eq("rst_pat", {28'd0, pat}, 32'hD);
    check_eq("rst_cnt", {24'd0, match_cnt}, 32'd0);
    rst = 1'b1; overlap = 1'b1;
    send(1'b1); send(1'b1); send(1'b0);
    check_eq("t1_z_early", {31'd0, z}, 32'd0);
    send(1'b1);
    check_eq("t1_z", {31'd0, z}, 32'd1);
    check_eq("t1_seq", {28'd0, seq}, 32'hD);
    check_eq("t1_cnt", {24'd0, match_cnt}, 32'd1);
    step();
    check_eq("t1_z_pulse", {31'd0, z}, 32'd0);

    // ---- Test 2: overlap vs non-overlap ----
    do_reset(); overlap = 1'b1;
    send7("t2_ov_z", 7'b1101101, 7'b0001001);
    check_eq("t2_ov_cnt", {24'd0, match_cnt}, 32'd2);
    do_reset(); overlap = 1'b0;
    send7("t2_nov_z", 7'b1101101, 7'b0001000);
    check_eq("t2_nov_cnt", {24'd0, match_cnt}, 32'd1);
    check_eq("t2_nov_seq", {28'd0, seq}, 32'h5);

    // ---- Test 3: bubbles with random x ----
    do_reset(); overlap = 1'b1;
    send(1'b1);
    for (int i = 0; i < 2; i++) begin x = 1'($urandom); step(); end
    send(1'b1);
    for (int i = 0; i < 3; i++) begin x = 1'($urandom); step(); end
    send(1'b0);
    x = 1'($urandom); step();
    check_eq("t3_seq_hold", {28'd0, seq}, 32'h6);
    check_eq("t3_z_early", {31'd0, z}, 32'd0);
    send(1'b1);
    check_eq("t3_z", {31'd0, z}, 32'd1);
    x = 1'($urandom); step();
    check_eq("t3_z_off", {31'd0, z}, 32'd0);
    check_eq("t3_cnt", {24'd0, match_cnt}, 32'd1);

    // ---- Test 4: pattern load beats x_valid ----
    do_reset(); overlap = 1'b1;
    send(1'b1); send(1'b0); send(1'b1);
    pat_load = 1'b1; pat_in = 4'b0110; pat_mask_in = 4'b1111; x = 1'b1; x_valid = 1'b1;
    step();
    pat_load = 1'b0; x_valid = 1'b0;
    check_eq("t4_seq", {28'd0, seq}, 32'h0);
    check_eq("t4_pat", {28'd0, pat}, 32'h6);
    check_eq("t4_z", {31'd0, z}, 32'd0);
    send(1'b0); send(1'b1); send(1'b1);
    check_eq("t4_z_early", {31'd0, z}, 32'd0);
    check_eq("t4_seq3", {28'd0, seq}, 32'h3);
    send(1'b0);
    check_eq("t4_z_hit", {31'd0, z}, 32'd1);
    check_eq("t4_cnt", {24'd0, match_cnt}, 32'd1);

    // ---- Test 5: saturation and clear-wins ----
    do_reset(); overlap = 1'b1;
    send(1'b1); send(1'b1); send(1'b0); send(1'b1);
    for (int i = 0; i < 4; i++) begin send(1'b1); send(1'b0); send(1'b1); end
    check_eq("t5_z", {31'd0, z2}, 32'd1);
    check_eq("t5_cnt8", {24'd0, match_cnt}, 32'd5);
    check_eq("t5_sat", {30'd0, match_cnt2}, 32'd3);
    send(1'b1); send(1'b0);
    cnt_clr = 1'b1;
    send(1'b1);
    cnt_clr = 1'b0;
    check_eq("t5_clr_z", {31'd0, z2}, 32'd1);
    check_eq("t5_clr_cnt2", {30'd0, match_cnt2}, 32'd0);
    check_eq("t5_clr_cnt8", {24'd0, match_cnt}, 32'd0);

    // ---- Test 6: reset mid-stream overrides everything ----
    do_reset();
    pat_load = 1'b1; pat_in = 4'b0110; step(); pat_load = 1'b0;
    send(1'b0); send(1'b1); send(1'b1);
    rst = 1'b0; x = 1'b0; x_valid = 1'b1; pat_load = 1'b1; pat_in = 4'b0011;
    step();
    rst = 1'b1; x_valid = 1'b0; pat_load = 1'b0;
    check_eq("t6_seq", {28'd0, seq}, 32'h0);
    check_eq("t6_z", {31'd0, z}, 32'd0);
    check_eq("t6_cnt", {24'd0, match_cnt}, 32'd0);
    check_eq("t6_pat", {28'd0, pat}, 32'hD);

`ifdef SEQ_DET_MASK_EN
    pat_load = 1'b1; pat_in = 4'b1101; pat_mask_in = 4'b1011; step(); pat_load = 1'b0;
    send(1'b1); send(1'b1); send(1'b1);
    check_eq("t6_mask_early", {31'd0, z}, 32'd0);
    send(1'b1);
    check_eq("t6_mask_hit", {31'd0, z}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised Moore serial pattern detector; successor to the team's fixed 4-bit detector.
- Adds run-time loadable pattern, valid-qualified input, overlap/non-overlap mode and a saturating match counter.
- Sits between a serial bit source and control logic or a 7-segment/LED status display.

Parameters:
- PAT_W, 4, pattern and window width in bits (min 2).
- CNT_W, 8, match counter width.
- PAT_RESET, 4'b1101 (PAT_W bits), pattern register value after reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low.
- x  input  1  serial data bit.
- x_valid  input  1  x is sampled only when high.
- overlap  input  1  1 = overlapping matches allowed, 0 = window restarts after a match.
- pat_load  input  1  one-cycle strobe; loads pat_in.
- pat_in  input  PAT_W  new pattern.
- cnt_clr  input  1  clears match_cnt.
- z  output  1  Moore match flag.
- seq  output  PAT_W  current shift window, newest bit at seq[0].
- pat  output  PAT_W  active pattern register.
- match_cnt  output  CNT_W  saturating match count.

Behaviour:
- Reset (rst==0 at posedge): state=FILL, seq=0, fill=0, pat=PAT_RESET, z=0, match_cnt=0. Reset overrides all other inputs, including mid-stream.
- Shift on posedge with x_valid=1: seq <= {seq[PAT_W-2:0], x}; fill saturates at PAT_W.
- x_valid=0: seq, fill and pat hold.
- States:
  - FILL: fewer than PAT_W valid bits held. Goes to MATCH when the shift makes fill==PAT_W and the new window equals pat. Goes to HUNT when fill reaches PAT_W without a match.
  - HUNT: goes to MATCH on a shift whose new window equals pat; otherwise stays.
  - MATCH: z=1.
    - With overlap=1: on a shift whose new window equals pat, stay in MATCH; otherwise go to HUNT (with or without a shift).
    - With overlap=0: always leave on the next edge. Window and fill are cleared, the bit shifted on that edge (if x_valid) becomes bit 1 of a new window, and next state is FILL.
- z = (state==MATCH), registered. Latency: z rises in the cycle after the edge that shifts in the final pattern bit. z is a one-cycle pulse per match unless back-to-back overlapping matches occur.
- match_cnt increments by 1 on each edge that enters or re-enters MATCH. It saturates at 2^CNT_W-1 and does not wrap.
- cnt_clr: match_cnt <= 0. If a match occurs on the same edge, clear wins and the result is 0.
- pat_load: pat <= pat_in; seq, fill <= 0; state <= FILL; z <= 0 next cycle; match_cnt unaffected. If x_valid is high on the same edge, load wins and that x is discarded.
- overlap is sampled every edge and may change mid-stream. It affects only the MATCH exit rule.

Optional Feature:
- Macro: SEQ_DET_MASK_EN.
- Defined: adds input pat_mask_in [PAT_W-1:0], loaded with pat_in on pat_load, into a mask register that resets to all-ones. Compare is ((seq ^ pat) & mask)==0; a mask bit of 0 makes that position don't-care.
- Undefined: no port, no mask register; exact compare.

Test Plan:
1. rst low 2 cycles, then release; x_valid=1, overlap=1, bits 1,1,0,1 -> z=1 exactly in the cycle after the 4th edge, seq=4'b1101, match_cnt=1.
2. Same pattern, bits 1,1,0,1,1,0,1:
   - overlap=1 -> z pulses after bits 4 and 7, match_cnt=2.
   - overlap=0 -> single pulse after bit 4, match_cnt=1.
3. Bits 1,1,0,1 with x_valid=0 bubbles between them, x toggling randomly during the bubbles -> one match, timed from the last valid edge.
4. After bits 1,0,1: pat_load with pat_in=4'b0110 while x_valid=1 -> that bit dropped, seq=0, pat=0110. Bits 0,1,1,0 -> match; no earlier bit contributes.
5. CNT_W=2, 5 matches -> match_cnt holds 3. Then cnt_clr on the same edge as a 6th match -> match_cnt=0, z still pulses.
6. After 3 bits and a loaded pattern 4'b0110: rst low one cycle -> seq=0, z=0, match_cnt=0, pat=4'b1101. With the macro defined: mask 4'b1011, pattern 1101, bits 1,1,1,1 -> match.
